// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential Goldschmidt FP divider.
// Holds the FSM state enum, IEEE-754 field widths and special encodings.
package fp_div_pkg;

  localparam int SIGN = 1;
  localparam int EXP  = 8;
  localparam int MANT = 23;

  localparam logic [EXP-1:0] BIAS_M1 = 8'd126;
  localparam logic [31:0]    FP_INF  = 32'h7F80_0000;
  localparam logic [31:0]    FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    MUL_N,
    MUL_D,
    SUBF,
    DONE
  } state_e;

endpackage

// File: rtl/fp_div_seq_two_minus.sv
// Combinational 2-D' for a divisor in [0.5, 2): fixed-point subtract,
// then renormalise to an FP value with exponent 127, or 126 when below one.
module fp_two_minus
  import fp_div_pkg::*;
(
  input  logic [31:0] d_in,
  output logic [31:0] f_out
);

  logic [24:0] dfix;
  logic [24:0] ffix;
  logic        unused_sign;

  assign unused_sign = d_in[31];

  // 1.24 fixed point; 2.0 wraps to zero so 2-D' is a plain negate
  always_comb begin
    dfix = {1'b1, d_in[MANT-1:0], 1'b0};
    if (d_in[30:23] == BIAS_M1) begin
      dfix = {2'b01, d_in[MANT-1:0]};
    end
    ffix = 25'd0 - dfix;
    if (ffix[24]) begin
      f_out = {1'b0, 8'd127, ffix[23:1]};
    end else begin
      f_out = {1'b0, BIAS_M1, ffix[22:0]};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential Goldschmidt divider using an external shared FP multiplier.
// Each iteration scales N' and D' by F=2-D' so D' converges to one.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int ITER = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] n_in,
  input  logic [31:0] d_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] q_out,
  output logic        dz,
  output logic        mul_req,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_ack,
  input  logic [31:0] mul_p
);

  state_e      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] d_q, d_d;
  logic [31:0] f_q, f_d;
  logic [31:0] q_q, q_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        s_q, s_d;
  logic        dzp_q, dzp_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;

  logic [EXP-1:0] en, ed;
  logic [9:0]     e_s;
  logic           sx;
  logic [31:0]    dn, nn, tm_in, tm_out;

  // operand prescaling: D' into [0.5,1), exponent difference into N'
  always_comb begin
    en  = n_q[30:23];
    ed  = d_q[30:23];
    sx  = n_q[31] ^ d_q[31];
    e_s = {2'b00, en} - {2'b00, ed} + {2'b00, BIAS_M1};
    dn  = {1'b0, BIAS_M1, d_q[MANT-1:0]};
    nn  = {sx, e_s[7:0], n_q[MANT-1:0]};
  end

  assign tm_in = (state_q == NORM) ? dn : d_q;

  fp_two_minus u_two_minus (
    .d_in  (tm_in),
    .f_out (tm_out)
  );

  // next-state and multiplier handshake
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    f_d     = f_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    dzp_d   = dzp_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    mul_req = 1'b0;
    mul_a   = 32'd0;
    mul_b   = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_in;
          d_d     = d_in;
          dzp_d   = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        state_d = DONE;
        s_d     = sx;
        if (ed == 8'd0) begin
          n_d   = FP_INF;
          dzp_d = 1'b1;
        end else if (en == 8'hFF || ed == 8'hFF) begin
          n_d = FP_QNAN;
          s_d = 1'b0;
        end else if (en == 8'd0) begin
          n_d = 32'd0;
        end else if ($signed(e_s) <= 10'sd0) begin
          n_d = 32'd0;
        end else if ($signed(e_s) >= 10'sd255) begin
          n_d = FP_INF;
        end else begin
          n_d     = nn;
          d_d     = dn;
          f_d     = tm_out;
          cnt_d   = 3'd0;
          state_d = MUL_N;
        end
      end
      MUL_N: begin
        mul_req = 1'b1;
        mul_a   = n_q;
        mul_b   = f_q;
        if (mul_ack) begin
          n_d     = mul_p;
          state_d = MUL_D;
        end
      end
      MUL_D: begin
        mul_req = 1'b1;
        mul_a   = d_q;
        mul_b   = f_q;
        if (mul_ack) begin
          d_d     = mul_p;
          state_d = SUBF;
        end
      end
      SUBF: begin
        f_d     = tm_out;
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_d == 3'(ITER)) ? DONE : MUL_N;
      end
      DONE: begin
        q_d     = {s_q, n_q[30:0]};
        dz_d    = dzp_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= 32'd0;
      d_q     <= 32'd0;
      f_q     <= 32'd0;
      q_q     <= 32'd0;
      cnt_q   <= 3'd0;
      s_q     <= 1'b0;
      dzp_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      f_q     <= f_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      dzp_q   <= dzp_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign q_out = q_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq with a behavioural shared multiplier.
// Expected quotients are exact three-step Goldschmidt values.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] n_in, d_in;
  logic        busy, done, dz;
  logic [31:0] q_out;
  logic        mul_req, mul_ack;
  logic [31:0] mul_a, mul_b, mul_p;

  int n_cmp = 0;
  int n_bad = 0;

  int ack_dly = 0;
  int wait_cnt = 0;
  logic ack_force = 1'b0;

  // 6/3: 1.5*1.25*1.0625*(257/256) = 65535/32768
  localparam logic [31:0] Q_6_3  = 32'h3FFF_FF00;
  // -1/4: -0.125*1.5*1.25*1.0625 = -255/1024
  localparam logic [31:0] Q_M1_4 = 32'hBE7F_0000;

  always #5 clk = ~clk;

  fp_div_seq #(.ITER(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .n_in    (n_in),
    .d_in    (d_in),
    .busy    (busy),
    .done    (done),
    .q_out   (q_out),
    .dz      (dz),
    .mul_req (mul_req),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_ack (mul_ack),
    .mul_p   (mul_p)
  );

  // truncating multiply for normal operands
  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    s = a[31] ^ b[31];
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    return {s, e[7:0], p[45:23]};
  endfunction

  assign mul_p   = fmul(mul_a, mul_b);
  assign mul_ack = ack_force | (mul_req && wait_cnt >= ack_dly);

  always @(posedge clk) begin
    if (mul_req && !mul_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                        output int lat, output bit req_seen);
    @(negedge clk);
    n_in = n;
    d_in = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    req_seen = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      req_seen |= mul_req;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    n_in = 32'd0;
    d_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, dz, mul_req} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got=%b want=0000",
               {busy, done, dz, mul_req});
    end
    n_cmp++;
    if (q_out !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_q got=%h want=0", q_out);
    end
    n_cmp++;
    if ({mul_a, mul_b} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_mul_ops got=%h/%h want=0/0", mul_a, mul_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_div_6_3();
    int lat;
    bit rs;
    logic [31:0] df;
    ack_dly = 0;
    run_op(32'h40C0_0000, 32'h4040_0000, lat, rs);
    n_cmp++;
    if (lat !== 11) begin
      n_bad++;
      $display("FAIL div63_latency got=%0d want=11", lat);
    end
    df = (q_out > Q_6_3) ? q_out - Q_6_3 : Q_6_3 - q_out;
    n_cmp++;
    if (df > 32'd1) begin
      n_bad++;
      $display("FAIL div63_q got=%h want=%h", q_out, Q_6_3);
    end
    n_cmp++;
    if (dz !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL div63_dz_busy got=%b%b want=00", dz, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q_out !== Q_6_3 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL div63_hold got=%h/%b want=%h/0",
               q_out, done, Q_6_3);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    bit rs;
    run_op(32'h3F80_0000, 32'h0000_0000, lat, rs);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL divzero_latency got=%0d want=2", lat);
    end
    n_cmp++;
    if (q_out !== 32'h7F80_0000 || dz !== 1'b1) begin
      n_bad++;
      $display("FAIL divzero_q got=%h/%b want=7f800000/1", q_out, dz);
    end
    n_cmp++;
    if (rs !== 1'b0) begin
      n_bad++;
      $display("FAIL divzero_mulreq got=%b want=0", rs);
    end
  endtask

  task automatic test_delayed_ack();
    int lat;
    bit stable;
    bit pr, pk;
    logic [31:0] pa, pb, df;
    ack_dly = 5;
    stable = 1'b1;
    pr = 1'b0;
    pk = 1'b0;
    pa = 32'd0;
    pb = 32'd0;
    lat = 0;
    @(negedge clk);
    n_in = 32'hBF80_0000;
    d_in = 32'h4080_0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (mul_req && pr && !pk && (mul_a !== pa || mul_b !== pb))
        stable = 1'b0;
      pr = mul_req;
      pk = mul_ack;
      pa = mul_a;
      pb = mul_b;
      if (done) begin
        lat = c;
        break;
      end
    end
    ack_dly = 0;
    n_cmp++;
    if (lat !== 41) begin
      n_bad++;
      $display("FAIL delayed_latency got=%0d want=41", lat);
    end
    df = (q_out > Q_M1_4) ? q_out - Q_M1_4 : Q_M1_4 - q_out;
    n_cmp++;
    if (df > 32'd1 || dz !== 1'b0) begin
      n_bad++;
      $display("FAIL delayed_q got=%h/%b want=%h/0", q_out, dz, Q_M1_4);
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_bad++;
      $display("FAIL delayed_operand_stable got=%b want=1", stable);
    end
  endtask

  task automatic test_busy_start();
    int dones;
    ack_dly = 0;
    dones = 0;
    @(negedge clk);
    n_in = 32'h40C0_0000;
    d_in = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_in = 32'h3F80_0000;
    d_in = 32'h0000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++;
      $display("FAIL busy_start_dones got=%0d want=1", dones);
    end
    n_cmp++;
    if (q_out !== Q_6_3 || dz !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_start_q got=%h/%b want=%h/0", q_out, dz, Q_6_3);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit rs;
    bit hit;
    bit saw_done;
    ack_dly = 3;
    hit = 1'b0;
    saw_done = 1'b0;
    @(negedge clk);
    n_in = 32'h40C0_0000;
    d_in = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (mul_req && mul_a === 32'h3F40_0000) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (hit !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_reach_muld got=%b want=1", hit);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || mul_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_abort got=%b%b want=00", busy, mul_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ack_force = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    ack_force = 1'b0;
    ack_dly = 0;
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_stale_ack got=%b want=0", saw_done);
    end
    run_op(32'h40C0_0000, 32'h4040_0000, lat, rs);
    n_cmp++;
    if (lat !== 11 || q_out !== Q_6_3 || dz !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_rerun got=%0d/%h/%b want=11/%h/0",
               lat, q_out, dz, Q_6_3);
    end
  endtask

  logic [31:0] sp_n [7] = '{32'h7F00_0000, 32'h0000_0000, 32'h8000_0000,
                            32'h7FC0_0000, 32'h0080_0000, 32'hBF80_0000,
                            32'h3F80_0000};
  logic [31:0] sp_d [7] = '{32'h0080_0000, 32'h4040_0000, 32'h4040_0000,
                            32'h3F80_0000, 32'h7F00_0000, 32'h8000_0000,
                            32'h0040_0000};
  logic [31:0] sp_q [7] = '{32'h7F80_0000, 32'h0000_0000, 32'h8000_0000,
                            32'h7FC0_0000, 32'h0000_0000, 32'h7F80_0000,
                            32'h7F80_0000};
  logic        sp_z [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic test_special();
    int lat;
    bit rs;
    for (int i = 0; i < 7; i++) begin
      run_op(sp_n[i], sp_d[i], lat, rs);
      n_cmp++;
      if (lat !== 2 || q_out !== sp_q[i] || dz !== sp_z[i] || rs) begin
        n_bad++;
        $display("FAIL special_%0d got=%0d/%h/%b/%b want=2/%h/%b/0",
                 i, lat, q_out, dz, rs, sp_q[i], sp_z[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div_6_3();
    test_div_zero();
    test_delayed_ack();
    test_busy_start();
    test_reset_mid();
    test_special();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
